// File: rtl/iob_split_pipe_pkg.sv
// Shared types and constants for the registered IOb bus splitter.
// Error codes, FSM encoding and bus-width helpers.
package iob_split_pipe_pkg;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_DECODE  = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    // {valid, addr, wdata, wstrb}
    function automatic int req_width(input int aw, input int dw);
        return 1 + aw + dw + dw / 8;
    endfunction

    // {rdata, ready}
    function automatic int resp_width(input int dw);
        return dw + 1;
    endfunction

endpackage

// File: rtl/iob_split_pipe_timer.sv
// Hung-slave watchdog: clearable up-counter with a terminal-count flag.
// A zero width removes the counter and the flag never fires.
module iob_split_pipe_timer #(
    parameter int W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    generate
        if (W > 0) begin : g_cnt
            logic [W-1:0] cnt;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt <= '0;
                end else if (clear) begin
                    cnt <= '0;
                end else if (enable && !tc) begin
                    cnt <= cnt + 1'b1;
                end
            end

            assign tc = &cnt;
        end else begin : g_off
            logic unused_tie;
            assign unused_tie = ^{clk, rst, clear, enable};
            assign tc = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/iob_split_pipe.sv
// Registered 1-master to N-slave IOb splitter with one outstanding transfer,
// decode-error and timeout responses.
module iob_split_pipe
    import iob_split_pipe_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int N_SLAVES  = 4,
    parameter int SEL_LSB   = ADDR_W - 3,
    parameter int SEL_W     = 2,
    parameter int TIMEOUT_W = 8,
    localparam int WSTRB_W  = DATA_W / 8,
    localparam int REQ_W    = req_width(ADDR_W, DATA_W),
    localparam int RESP_W   = resp_width(DATA_W)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [REQ_W-1:0]           m_req,
    output logic [RESP_W-1:0]          m_resp,
    output logic [N_SLAVES*REQ_W-1:0]  s_req,
    input  logic [N_SLAVES*RESP_W-1:0] s_resp,
    output logic                       err,
    output logic [1:0]                 err_code
);

    localparam logic [SEL_W:0] N_LIM = (SEL_W + 1)'(N_SLAVES);

    logic               m_valid;
    logic [ADDR_W-1:0]  m_addr;
    logic [DATA_W-1:0]  m_wdata;
    logic [WSTRB_W-1:0] m_wstrb;
    logic [SEL_W-1:0]   m_sel;
    logic               mapped;

    assign m_valid = m_req[REQ_W-1];
    assign m_addr  = m_req[REQ_W-2 -: ADDR_W];
    assign m_wdata = m_req[DATA_W+WSTRB_W-1 -: DATA_W];
    assign m_wstrb = m_req[WSTRB_W-1:0];
    assign m_sel   = m_addr[SEL_LSB +: SEL_W];
    assign mapped  = {1'b0, m_sel} < N_LIM;

    state_t             state;
    state_t             state_n;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [WSTRB_W-1:0] wstrb_q;
    logic [SEL_W-1:0]   sel_q;
    logic [1:0]         err_code_q;

    logic               capture;
    logic               tc;
    logic               timer_en;
    logic               sel_ready;
    logic [DATA_W-1:0]  sel_rdata;
    logic [N_SLAVES-1:0] s_valid;
    logic               m_ready;
    logic [DATA_W-1:0]  m_rdata;
    logic               err_pulse;
    logic [1:0]         code_n;

    // Only the selected slave's response is ever looked at.
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (sel_q == SEL_W'(i)) begin
                sel_ready = s_resp[i*RESP_W];
                sel_rdata = s_resp[i*RESP_W+1 +: DATA_W];
            end
        end
    end

    always_comb begin
        s_valid = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            s_valid[i] = (state == ST_WAIT) && !tc &&
                         (sel_q == SEL_W'(i));
        end
    end

    assign timer_en = (state == ST_WAIT) && !sel_ready;

    iob_split_pipe_timer #(
        .W(TIMEOUT_W)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (capture),
        .enable(timer_en),
        .tc    (tc)
    );

    always_comb begin
        state_n   = state;
        capture   = 1'b0;
        m_ready   = 1'b0;
        m_rdata   = '0;
        err_pulse = 1'b0;
        code_n    = ERR_NONE;
        unique case (state)
            ST_IDLE: begin
                if (m_valid) begin
                    capture = 1'b1;
                    state_n = mapped ? ST_WAIT : ST_ERR;
                end
            end
            ST_WAIT: begin
                // A ready on the terminal cycle still completes normally.
                if (sel_ready) begin
                    m_ready = 1'b1;
                    m_rdata = sel_rdata;
                    state_n = ST_IDLE;
                end else if (tc) begin
                    m_ready   = 1'b1;
                    err_pulse = 1'b1;
                    code_n    = ERR_TIMEOUT;
                    state_n   = ST_IDLE;
                end
            end
            ST_ERR: begin
                m_ready   = 1'b1;
                err_pulse = 1'b1;
                code_n    = ERR_DECODE;
                state_n   = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            sel_q      <= '0;
            err_code_q <= ERR_NONE;
        end else begin
            state <= state_n;
            if (capture) begin
                addr_q  <= m_addr;
                wdata_q <= m_wdata;
                wstrb_q <= m_wstrb;
                sel_q   <= m_sel;
            end
            if (err_pulse) begin
                err_code_q <= code_n;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < N_SLAVES; g++) begin : g_sreq
            assign s_req[g*REQ_W +: REQ_W] =
                {s_valid[g], addr_q, wdata_q, wstrb_q};
        end
    endgenerate

    assign m_resp   = {m_rdata, m_ready};
    assign err      = err_pulse;
    assign err_code = err_pulse ? code_n : err_code_q;

endmodule
